// File: rtl/rv_id_ex_reg.sv
// ID/EX pipeline register with load-use hazard detection.
// Define RV_IDEX_PERF_EN to add the bubble_cnt hazard-bubble performance counter.
module rv_id_ex_reg #(
    parameter int unsigned XLEN = 64
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            id_valid,
    input  logic [XLEN-1:0] id_pc,
    input  logic [XLEN-1:0] id_rs1_data,
    input  logic [XLEN-1:0] id_rs2_data,
    input  logic [XLEN-1:0] id_imm,
    input  logic [4:0]      id_rs1,
    input  logic [4:0]      id_rs2,
    input  logic [4:0]      id_rd,
    input  logic [3:0]      id_funct,
    input  logic [1:0]      id_alu_op,
    input  logic            id_alusrc,
    input  logic            id_memtoreg,
    input  logic            id_regwrite,
    input  logic            id_memread,
    input  logic            id_memwrite,
    input  logic            id_branch,
    input  logic            ext_stall,
    input  logic            flush,
    output logic            ex_valid,
    output logic [XLEN-1:0] ex_pc,
    output logic [XLEN-1:0] ex_rs1_data,
    output logic [XLEN-1:0] ex_rs2_data,
    output logic [XLEN-1:0] ex_imm,
    output logic [4:0]      ex_rs1,
    output logic [4:0]      ex_rs2,
    output logic [4:0]      ex_rd,
    output logic [3:0]      ex_funct,
    output logic [1:0]      ex_alu_op,
    output logic            ex_alusrc,
    output logic            ex_memtoreg,
    output logic            ex_regwrite,
    output logic            ex_memread,
    output logic            ex_memwrite,
    output logic            ex_branch,
`ifdef RV_IDEX_PERF_EN
    output logic [31:0]     bubble_cnt,
`endif
    output logic            hazard_stall
);

    logic bubble;
    logic kill_ctrl;

    // rs2 is compared for every format; a spurious stall is harmless.
    assign hazard_stall = ex_valid & ex_memread & (ex_rd != 5'd0) & id_valid &
                          ((ex_rd == id_rs1) | (ex_rd == id_rs2));

    assign bubble    = flush | hazard_stall;
    assign kill_ctrl = bubble | ~id_valid;

    always_ff @(posedge clk) begin
        if (rst) begin
            ex_valid    <= 1'b0;
            ex_pc       <= '0;
            ex_rs1_data <= '0;
            ex_rs2_data <= '0;
            ex_imm      <= '0;
            ex_rs1      <= 5'd0;
            ex_rs2      <= 5'd0;
            ex_rd       <= 5'd0;
            ex_funct    <= 4'd0;
            ex_alu_op   <= 2'd0;
            ex_alusrc   <= 1'b0;
            ex_memtoreg <= 1'b0;
            ex_regwrite <= 1'b0;
            ex_memread  <= 1'b0;
            ex_memwrite <= 1'b0;
            ex_branch   <= 1'b0;
        end else if (!ext_stall) begin
            // Data and index fields load even for a bubble; only control is squashed.
            ex_pc       <= id_pc;
            ex_rs1_data <= id_rs1_data;
            ex_rs2_data <= id_rs2_data;
            ex_imm      <= id_imm;
            ex_rs1      <= id_rs1;
            ex_rs2      <= id_rs2;
            ex_rd       <= id_rd;
            ex_funct    <= id_funct;
            ex_valid    <= id_valid & ~bubble;
            ex_alu_op   <= kill_ctrl ? 2'd0 : id_alu_op;
            ex_alusrc   <= id_alusrc   & ~kill_ctrl;
            ex_memtoreg <= id_memtoreg & ~kill_ctrl;
            ex_regwrite <= id_regwrite & ~kill_ctrl;
            ex_memread  <= id_memread  & ~kill_ctrl;
            ex_memwrite <= id_memwrite & ~kill_ctrl;
            ex_branch   <= id_branch   & ~kill_ctrl;
        end
    end

`ifdef RV_IDEX_PERF_EN
    // Counts hazard bubbles only; a coincident flush claims the bubble.
    always_ff @(posedge clk) begin
        if (rst) begin
            bubble_cnt <= 32'd0;
        end else if (!ext_stall && !flush && hazard_stall && (bubble_cnt != 32'hFFFF_FFFF)) begin
            bubble_cnt <= bubble_cnt + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_rv_id_ex_reg.sv
// Scoreboard bench for rv_id_ex_reg: a behavioural model pushes the expected EX state per edge.
module tb_rv_id_ex_reg;

    typedef struct packed {
        logic        valid;
        logic [63:0] pc;
        logic [63:0] rs1d;
        logic [63:0] rs2d;
        logic [63:0] imm;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic [4:0]  rd;
        logic [3:0]  funct;
        logic [1:0]  alu_op;
        logic [5:0]  ctl;   // {alusrc, memtoreg, regwrite, memread, memwrite, branch}
        logic [31:0] bcnt;
    } ex_t;

    logic        clk = 1'b0;
    logic        rst, id_valid, ext_stall, flush;
    logic [63:0] id_pc, id_rs1_data, id_rs2_data, id_imm;
    logic [4:0]  id_rs1, id_rs2, id_rd;
    logic [3:0]  id_funct;
    logic [1:0]  id_alu_op;
    logic [5:0]  id_ctl;
    logic        ex_valid, ex_alusrc, ex_memtoreg, ex_regwrite, ex_memread, ex_memwrite;
    logic        ex_branch, hazard_stall;
    logic [63:0] ex_pc, ex_rs1_data, ex_rs2_data, ex_imm;
    logic [4:0]  ex_rs1, ex_rs2, ex_rd;
    logic [3:0]  ex_funct;
    logic [1:0]  ex_alu_op;
    logic [31:0] bubble_cnt;

    ex_t m;
    ex_t q[$];
    bit  known = 1'b0;
    int  n_vec = 0;
    int  n_err = 0;

    always #5 clk = ~clk;

`ifndef RV_IDEX_PERF_EN
    assign bubble_cnt = 32'd0;
`endif

    rv_id_ex_reg dut (
        .clk          (clk),
        .rst          (rst),
        .id_valid     (id_valid),
        .id_pc        (id_pc),
        .id_rs1_data  (id_rs1_data),
        .id_rs2_data  (id_rs2_data),
        .id_imm       (id_imm),
        .id_rs1       (id_rs1),
        .id_rs2       (id_rs2),
        .id_rd        (id_rd),
        .id_funct     (id_funct),
        .id_alu_op    (id_alu_op),
        .id_alusrc    (id_ctl[5]),
        .id_memtoreg  (id_ctl[4]),
        .id_regwrite  (id_ctl[3]),
        .id_memread   (id_ctl[2]),
        .id_memwrite  (id_ctl[1]),
        .id_branch    (id_ctl[0]),
        .ext_stall    (ext_stall),
        .flush        (flush),
        .ex_valid     (ex_valid),
        .ex_pc        (ex_pc),
        .ex_rs1_data  (ex_rs1_data),
        .ex_rs2_data  (ex_rs2_data),
        .ex_imm       (ex_imm),
        .ex_rs1       (ex_rs1),
        .ex_rs2       (ex_rs2),
        .ex_rd        (ex_rd),
        .ex_funct     (ex_funct),
        .ex_alu_op    (ex_alu_op),
        .ex_alusrc    (ex_alusrc),
        .ex_memtoreg  (ex_memtoreg),
        .ex_regwrite  (ex_regwrite),
        .ex_memread   (ex_memread),
        .ex_memwrite  (ex_memwrite),
        .ex_branch    (ex_branch),
`ifdef RV_IDEX_PERF_EN
        .bubble_cnt   (bubble_cnt),
`endif
        .hazard_stall (hazard_stall)
    );

    task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic set_id(input logic v, input logic [63:0] pc, input logic [4:0] rs1,
                          input logic [4:0] rs2, input logic [4:0] rd, input logic [1:0] aop,
                          input logic [5:0] ctl);
        id_valid    = v;
        id_pc       = pc;
        id_rs1      = rs1;
        id_rs2      = rs2;
        id_rd       = rd;
        id_alu_op   = aop;
        id_ctl      = ctl;
        id_rs1_data = {$urandom, $urandom};
        id_rs2_data = {$urandom, $urandom};
        id_imm      = {$urandom, $urandom};
        id_funct    = 4'($urandom);
    endtask

    task automatic ctrl(input logic r, input logic s, input logic f);
        rst       = r;
        ext_stall = s;
        flush     = f;
    endtask

    // Called just after a falling edge with inputs already driven.
    task automatic step();
        ex_t  nx;
        ex_t  e;
        logic haz;
        logic bub;
        logic kill;
        #1;
        haz = m.valid && m.ctl[2] && (m.rd != 5'd0) && id_valid &&
              ((m.rd == id_rs1) || (m.rd == id_rs2));
        if (known) check_val("hazard_stall", 64'(hazard_stall), 64'(haz));
        nx = m;
        if (rst) begin
            nx = '0;
        end else if (!ext_stall) begin
            bub       = flush || haz;
            kill      = bub || !id_valid;
            nx.pc     = id_pc;
            nx.rs1d   = id_rs1_data;
            nx.rs2d   = id_rs2_data;
            nx.imm    = id_imm;
            nx.rs1    = id_rs1;
            nx.rs2    = id_rs2;
            nx.rd     = id_rd;
            nx.funct  = id_funct;
            nx.valid  = id_valid && !bub;
            nx.alu_op = kill ? 2'd0 : id_alu_op;
            nx.ctl    = kill ? 6'd0 : id_ctl;
            if (haz && !flush && m.bcnt != 32'hFFFF_FFFF) nx.bcnt = m.bcnt + 32'd1;
        end
        if (rst) known = 1'b1;
        m = nx;
        q.push_back(nx);
        @(posedge clk);
        #1;
        if (known && q.size() != 0) begin
            e = q.pop_front();
            check_val("ex_valid", 64'(ex_valid), 64'(e.valid));
            check_val("ex_pc", ex_pc, e.pc);
            check_val("ex_rs1_data", ex_rs1_data, e.rs1d);
            check_val("ex_rs2_data", ex_rs2_data, e.rs2d);
            check_val("ex_imm", ex_imm, e.imm);
            check_val("ex_idx", 64'({ex_rs1, ex_rs2, ex_rd, ex_funct}),
                      64'({e.rs1, e.rs2, e.rd, e.funct}));
            check_val("ex_ctrl", 64'({ex_alu_op, ex_alusrc, ex_memtoreg, ex_regwrite,
                                      ex_memread, ex_memwrite, ex_branch}),
                      64'({e.alu_op, e.ctl}));
`ifdef RV_IDEX_PERF_EN
            check_val("bubble_cnt", 64'(bubble_cnt), 64'(e.bcnt));
`endif
        end else begin
            void'(q.pop_front());
        end
        @(negedge clk);
    endtask

    localparam logic [5:0] CtlAlu  = 6'b001000; // regwrite
    localparam logic [5:0] CtlLoad = 6'b111100; // alusrc, memtoreg, regwrite, memread

    initial begin
        m = '0;
        ctrl(1'b1, 1'b0, 1'b0);
        set_id(1'b0, 64'd0, 5'd0, 5'd0, 5'd0, 2'd0, 6'd0);
        @(negedge clk);
        step();
        step();

        // Normal load
        ctrl(1'b0, 1'b0, 1'b0);
        set_id(1'b1, 64'h100, 5'd1, 5'd2, 5'd5, 2'd2, CtlAlu);
        step();
        check_val("normal_pc", ex_pc, 64'h100);
        check_val("normal_rd", 64'(ex_rd), 64'd5);

        // Load-use on rs1, then hazard self-clears after one bubble
        set_id(1'b1, 64'h104, 5'd1, 5'd2, 5'd7, 2'd0, CtlLoad);
        step();
        set_id(1'b1, 64'h108, 5'd7, 5'd3, 5'd8, 2'd2, CtlAlu);
        step();
        check_val("loaduse_bubble_valid", 64'(ex_valid), 64'd0);
        step();

        // x0 load never stalls
        set_id(1'b1, 64'h10c, 5'd1, 5'd2, 5'd0, 2'd0, CtlLoad);
        step();
        set_id(1'b1, 64'h110, 5'd0, 5'd0, 5'd9, 2'd2, CtlAlu);
        step();

        // Hold for 3 cycles with a pending hazard on rs2, then release
        set_id(1'b1, 64'h114, 5'd1, 5'd2, 5'd9, 2'd0, CtlLoad);
        step();
        ctrl(1'b0, 1'b1, 1'b0);
        for (int i = 0; i < 3; i++) begin
            set_id(1'b1, 64'h200 + 64'(i), 5'd4, 5'd9, 5'd10, 2'd1, CtlAlu);
            step();
        end
        ctrl(1'b0, 1'b0, 1'b0);
        step();
        step();

        // Flush coinciding with a hazard: one bubble, not counted
        set_id(1'b1, 64'h118, 5'd1, 5'd2, 5'd7, 2'd0, CtlLoad);
        step();
        ctrl(1'b0, 1'b0, 1'b1);
        set_id(1'b1, 64'h11c, 5'd7, 5'd7, 5'd3, 2'd2, CtlAlu);
        step();
        ctrl(1'b0, 1'b0, 1'b0);
        step();

        // Reset while a load sits in EX and a hazard is pending
        set_id(1'b1, 64'h120, 5'd1, 5'd2, 5'd3, 2'd0, CtlLoad);
        step();
        ctrl(1'b1, 1'b1, 1'b1);
        set_id(1'b1, 64'h124, 5'd3, 5'd0, 5'd4, 2'd2, CtlAlu);
        step();
        check_val("reset_valid", 64'(ex_valid), 64'd0);
        ctrl(1'b0, 1'b0, 1'b0);
        step();

        // Random traffic over a small register space to provoke hazards
        for (int i = 0; i < 400; i++) begin
            ctrl(($urandom_range(0, 49) == 0), ($urandom_range(0, 4) == 0),
                 ($urandom_range(0, 7) == 0));
            set_id(($urandom_range(0, 5) != 0), {$urandom, $urandom},
                   5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)),
                   5'($urandom_range(0, 3)), 2'($urandom), 6'($urandom));
            step();
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
